// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write sequencer:
// FSM states, command bytes and the power-up init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        IDLE
    } lcd_state_t;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_HOME    = 8'h02;

    localparam int INIT_LEN = 4;

    typedef logic [15:0] tick_cnt_t;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] value;
        case (idx)
            2'd0:    value = CMD_FUNCSET;
            2'd1:    value = CMD_DISPON;
            2'd2:    value = CMD_CLEAR;
            default: value = CMD_ENTRY;
        endcase
        return value;
    endfunction

    // Clear and home are the slow LCD instructions that need the long hold.
    function automatic logic is_long_cmd(input logic [7:0] data, input logic rs);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable so a
// freshly launched command always gets full-length phases.
module lcd_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/lcd_sequencer.sv
// LCD write sequencer: runs the power-up init ROM, then accepts host bytes
// and strobes each one onto the LCD bus with setup, pulse and hold phases.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int TICK_DIV      = 50000,
    parameter int POWERUP_TICKS = 20,
    parameter int CMD_TICKS     = 2,
    parameter int CLR_TICKS     = 5
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    lcd_state_t state, state_next;
    tick_cnt_t  tick_cnt, tick_cnt_next;
    tick_cnt_t  hold_last;
    logic [2:0] rom_idx;
    logic       tick;
    logic       restart;
    logic       load_byte;
    logic       rom_inc;
    logic       set_done;
    logic [7:0] byte_next;
    logic       rs_next;

    lcd_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clock_in(clock_in),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    assign hold_last = is_long_cmd(lcd_data, lcd_rs) ? tick_cnt_t'(CLR_TICKS - 1)
                                                     : tick_cnt_t'(CMD_TICKS - 1);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= POWERUP;
            tick_cnt <= '0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            rom_idx   <= '0;
            init_done <= 1'b0;
        end else begin
            if (load_byte) begin
                lcd_data <= byte_next;
                lcd_rs   <= rs_next;
            end
            if (rom_inc) begin
                rom_idx <= rom_idx + 3'd1;
            end
            if (set_done) begin
                init_done <= 1'b1;
            end
        end
    end

    // Only LOAD and an accepted host write move without waiting for a tick.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        restart       = 1'b0;
        load_byte     = 1'b0;
        rom_inc       = 1'b0;
        set_done      = 1'b0;
        byte_next     = wr_data;
        rs_next       = wr_rs;
        case (state)
            POWERUP: begin
                if (tick) begin
                    if (tick_cnt == tick_cnt_t'(POWERUP_TICKS - 1)) begin
                        state_next    = LOAD;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt + tick_cnt_t'(1);
                    end
                end
            end
            LOAD: begin
                state_next = SETUP;
                restart    = 1'b1;
                load_byte  = 1'b1;
                rom_inc    = 1'b1;
                byte_next  = init_rom(rom_idx[1:0]);
                rs_next    = 1'b0;
            end
            SETUP: begin
                if (tick) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (tick) begin
                    state_next    = HOLD;
                    tick_cnt_next = '0;
                end
            end
            HOLD: begin
                if (tick) begin
                    if (tick_cnt == hold_last) begin
                        tick_cnt_next = '0;
                        if (rom_idx != 3'(INIT_LEN)) begin
                            state_next = LOAD;
                        end else begin
                            state_next = IDLE;
                            set_done   = 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + tick_cnt_t'(1);
                    end
                end
            end
            IDLE: begin
                if (wr_valid) begin
                    state_next = SETUP;
                    restart    = 1'b1;
                    load_byte  = 1'b1;
                end
            end
            default: begin
                state_next = POWERUP;
            end
        endcase
    end

    assign lcd_en   = (state == PULSE);
    assign wr_ready = (state == IDLE);
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: predicts every LCD strobe and host acceptance from
// a timeline model and compares against pulses observed on the LCD bus.
module tb_lcd_sequencer;

    localparam int TICK_DIV      = 4;
    localparam int POWERUP_TICKS = 3;
    localparam int CMD_TICKS     = 2;
    localparam int CLR_TICKS     = 5;

    typedef struct {
        int         rise;
        int         width;
        logic [7:0] data;
        logic       rs;
        logic       stable;
    } pulse_t;

    logic       clock_in;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    int     cyc = 0;
    int     check_cnt = 0;
    int     pass_cnt = 0;
    int     ready_at;
    int     done_cyc = -1;
    pulse_t pulse_q[$];
    pulse_t exp_q[$];

    pulse_t cur;
    logic   prev_en = 1'b0;
    logic   prev_done = 1'b0;

    lcd_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .POWERUP_TICKS(POWERUP_TICKS),
        .CMD_TICKS    (CMD_TICKS),
        .CLR_TICKS    (CLR_TICKS)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .init_done(init_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    // Bus monitor: records every completed enable strobe and the init_done rise.
    always @(negedge clock_in) begin
        if (lcd_en && !prev_en) begin
            cur.rise   = cyc;
            cur.data   = lcd_data;
            cur.rs     = lcd_rs;
            cur.stable = 1'b1;
        end else if (lcd_en) begin
            if (lcd_data !== cur.data || lcd_rs !== cur.rs) cur.stable = 1'b0;
        end else if (prev_en) begin
            cur.width = cyc - cur.rise;
            pulse_q.push_back(cur);
        end
        prev_en = lcd_en;
        if (init_done && !prev_done) done_cyc = cyc;
        prev_done = init_done;
    end

    function automatic int hold_cycles(input logic [7:0] d, input logic rs);
        if (!rs && (d == 8'h01 || d == 8'h02)) return CLR_TICKS * TICK_DIV;
        return CMD_TICKS * TICK_DIV;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_pulse(input int rise, input logic [7:0] d, input logic rs);
        pulse_t p;
        p.rise = rise; p.width = TICK_DIV; p.data = d; p.rs = rs; p.stable = 1'b1;
        exp_q.push_back(p);
    endtask

    // Timeline of the init ROM after release at cycle rel; returns first IDLE cycle.
    task automatic model_init(input int rel, output int first_idle);
        logic [7:0] rom [4];
        int r;
        rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
        r = rel + POWERUP_TICKS * TICK_DIV + 1 + TICK_DIV;
        for (int i = 0; i < 4; i++) begin
            expect_pulse(r, rom[i], 1'b0);
            first_idle = r + TICK_DIV + hold_cycles(rom[i], 1'b0);
            r = first_idle + 1 + TICK_DIV;
        end
        ready_at = first_idle;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic r, output int acc);
        acc = -1;
        wr_data  = d;
        wr_rs    = r;
        wr_valid = 1'b1;
        for (int n = 0; n < 600 && acc < 0; n++) begin
            if (wr_ready) acc = cyc;
            @(negedge clock_in);
        end
        wr_valid = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [7:0] d, input logic r, output int acc);
        int p, exp_acc;
        p = cyc;
        exp_acc = (p > ready_at) ? p : ready_at;
        apply_stimulus(d, r, acc);
        check_output(tag, acc, exp_acc);
        expect_pulse(exp_acc + 1 + TICK_DIV, d, r);
        ready_at = exp_acc + 1 + 2 * TICK_DIV + hold_cycles(d, r);
    endtask

    task automatic compare_pulses(input string tag);
        int n;
        check_output({tag, "_count"}, pulse_q.size(), exp_q.size());
        n = (pulse_q.size() < exp_q.size()) ? pulse_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_rise%0d", tag, i), pulse_q[i].rise, exp_q[i].rise);
            check_output($sformatf("%s_width%0d", tag, i), pulse_q[i].width, exp_q[i].width);
            check_output($sformatf("%s_data%0d", tag, i), pulse_q[i].data, exp_q[i].data);
            check_output($sformatf("%s_rs%0d", tag, i), pulse_q[i].rs, exp_q[i].rs);
            check_output($sformatf("%s_stable%0d", tag, i), pulse_q[i].stable, exp_q[i].stable);
        end
        pulse_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int rel, init_idle, acc, acc_prev, acc_home;
        int found;
        logic [7:0] d;
        logic r;

        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        repeat (3) @(negedge clock_in);

        check_output("rst_en", lcd_en, 1'b0);
        check_output("rst_data", lcd_data, 8'h00);
        check_output("rst_rs", lcd_rs, 1'b0);
        check_output("rst_rw", lcd_rw, 1'b0);
        check_output("rst_ready", wr_ready, 1'b0);
        check_output("rst_done", init_done, 1'b0);

        // Host holds 0x41 from release; it must wait out the whole init.
        rel = cyc;
        reset_n = 1'b1;
        model_init(rel, init_idle);
        do_write("accept_during_init", 8'h41, 1'b1, acc);
        check_output("init_done_cycle", done_cyc, init_idle);
        check_output("init_done_sticky", init_done, 1'b1);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge clock_in);
            d = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                d = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
                r = 1'b0;
            end
            do_write($sformatf("rand_accept%0d", k), d, r, acc);
        end

        do_write("b2b_0", 8'h48, 1'b1, acc_prev);
        do_write("b2b_1", 8'h49, 1'b1, acc);
        check_output("b2b_gap1", acc - acc_prev, 17);
        acc_prev = acc;
        do_write("b2b_2", 8'h21, 1'b1, acc);
        check_output("b2b_gap2", acc - acc_prev, 17);

        do_write("home_cmd", 8'h02, 1'b0, acc_home);
        do_write("setddram_cmd", 8'h80, 1'b0, acc);
        check_output("home_hold_gap", acc - acc_home, 29);

        while (cyc < ready_at) @(negedge clock_in);
        check_output("idle_ready", wr_ready, 1'b1);
        check_output("rw_low", lcd_rw, 1'b0);
        compare_pulses("run1");

        // Reset in the middle of a strobe, then the init timeline must repeat.
        apply_stimulus(8'h55, 1'b1, acc);
        check_output("pre_reset_accept", acc >= 0, 1'b1);
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            @(negedge clock_in);
            if (lcd_en) found = 1;
        end
        check_output("pulse_before_reset", found, 1);
        #1 reset_n = 1'b0;
        #1;
        check_output("async_en", lcd_en, 1'b0);
        check_output("async_done", init_done, 1'b0);
        check_output("async_ready", wr_ready, 1'b0);
        check_output("async_data", lcd_data, 8'h00);
        repeat (2) @(negedge clock_in);
        pulse_q.delete();
        exp_q.delete();

        rel = cyc;
        reset_n = 1'b1;
        model_init(rel, init_idle);
        while (cyc < init_idle + 1) @(negedge clock_in);
        check_output("reinit_done_cycle", done_cyc, init_idle);
        check_output("reinit_ready", wr_ready, 1'b1);
        compare_pulses("run2");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning clock_in cycles per timing tick (1 ms at 50 MHz, legal range >=1).
REQ-002 The block SHALL have parameter POWERUP_TICKS, default 20, meaning the number of ticks to wait after reset before the first LCD command.
REQ-003 The block SHALL have parameter CMD_TICKS, default 2, meaning the post-pulse hold in ticks for ordinary commands and data.
REQ-004 The block SHALL have parameter CLR_TICKS, default 5, meaning the post-pulse hold in ticks for commands 0x01 (clear) and 0x02 (home), when lcd_rs=0.
REQ-005 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  clock_in  in  1  single clock; all logic on its rising edge
  reset_n  in  1  asynchronous, active-low reset
  wr_valid  in  1  host has a byte to write
  wr_rs  in  1  0=command byte, 1=character data byte
  wr_data  in  8  byte to write
  wr_ready  out  1  block can accept a byte this cycle
  init_done  out  1  power-up init sequence completed
  lcd_data  out  8  LCD DB7..DB0
  lcd_rs  out  1  LCD register select
  lcd_rw  out  1  LCD read/write, tied 0 (write only)
  lcd_en  out  1  LCD enable strobe

Function
REQ-006 The internal prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle tick when it reaches TICK_DIV-1, then wrap to 0; it SHALL restart at 0 in the cycle any command is launched.
REQ-007 The FSM SHALL use states POWERUP, LOAD, SETUP, PULSE, HOLD and IDLE, and all transitions except IDLE->SETUP and LOAD->SETUP SHALL occur only on tick cycles.
REQ-008 POWERUP SHALL last exactly POWERUP_TICKS ticks, after which the FSM SHALL go to LOAD.
REQ-009 LOAD SHALL issue the init ROM entries in order 0x38, 0x0C, 0x01, 0x06, each with lcd_rs=0, and each entry SHALL go to SETUP in the following cycle.
REQ-010 In SETUP, lcd_data and lcd_rs SHALL be stable and lcd_en=0 for exactly TICK_DIV cycles.
REQ-011 In PULSE, lcd_en=1 for exactly TICK_DIV cycles, with lcd_data and lcd_rs unchanged.
REQ-012 In HOLD, lcd_en=0 with lcd_data and lcd_rs held, for CLR_TICKS*TICK_DIV cycles if the byte is 0x01 or 0x02 with lcd_rs=0, otherwise for CMD_TICKS*TICK_DIV cycles.
REQ-013 After HOLD, the FSM SHALL return to LOAD if init entries remain, otherwise it SHALL set init_done=1 (sticky until reset) and go to IDLE.
REQ-014 wr_ready SHALL be 1 only in IDLE, and a transfer SHALL occur in any cycle where wr_valid and wr_ready are both 1.
REQ-015 On a transfer, wr_data and wr_rs SHALL be captured, and the next cycle SHALL be SETUP with lcd_data=wr_data, lcd_rs=wr_rs and wr_ready=0.
REQ-016 wr_valid while wr_ready=0 (during init or a write) SHALL be ignored without side effects, and the host SHALL hold its byte until accepted.
REQ-017 Back-to-back writes SHALL be accepted in the first IDLE cycle after the previous HOLD, so the minimum write period is (2+CMD_TICKS)*TICK_DIV+1 cycles.
REQ-018 With TICK_DIV=1, tick SHALL be asserted every cycle and all durations SHALL scale exactly.
REQ-019 lcd_rw SHALL be constant 0.

Reset
REQ-020 When reset_n=0, the block SHALL asynchronously set state=POWERUP, prescaler=0, tick counter=0, ROM index=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, wr_ready=0 and init_done=0.
REQ-021 A reset asserted mid-pulse SHALL drop lcd_en immediately, and after release the full power-up sequence SHALL restart.

Structure
REQ-022 Package lcd_pkg SHALL hold the state enumeration, the init ROM contents and the command constants CMD_FUNCSET=0x38, CMD_DISPON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06 and CMD_HOME=0x02.
REQ-023 The prescaler SHALL be a sub-module, lcd_tick_gen, with ports clock_in, reset_n, restart and tick.

Verification
(Bench parameters: TICK_DIV=4, POWERUP_TICKS=3, CMD_TICKS=2, CLR_TICKS=5.)
REQ-024 Release reset -> the first lcd_en rise SHALL occur 12+1+4 cycles after release with lcd_data=0x38, and lcd_en SHALL be high for exactly 4 cycles.
REQ-025 Full init -> SHALL produce exactly 4 lcd_en pulses carrying 0x38, 0x0C, 0x01, 0x06; the hold after 0x01 SHALL be 20 cycles and the others 8; then init_done=1 and wr_ready=1.
REQ-026 Hold wr_valid=1 with wr_data=0x41 throughout init -> no extra pulse SHALL occur, and the byte SHALL be accepted in the first IDLE cycle and pulsed with lcd_rs=1 per wr_rs.
REQ-027 Three back-to-back data writes 0x48, 0x49, 0x21 -> wr_ready acceptances SHALL be spaced exactly 17 cycles apart, in order.
REQ-028 Write command 0x02 -> its hold SHALL be 20 cycles, and a following write of 0x80 SHALL get an 8-cycle hold.
REQ-029 Assert reset_n=0 in the middle of a PULSE -> lcd_en, init_done and wr_ready SHALL go to 0 asynchronously before the next edge, and after release the REQ-024 timing SHALL repeat.
